// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one shared prefix adder/subtractor, with a single
// registered result slot that can be refilled every cycle while the consumer drains it.

module addsub #(
   parameter int width = 8,
   parameter int speed = 2
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             sub,
   output logic [width-1:0] s
);
   // Only the low width-1 group carries feed sum bits; the MSB carry out is dropped.
   localparam int Pw = width - 1;
   localparam int Lv = (Pw > 1) ? $clog2(Pw) : 1;

   logic [width-1:0] b_eff;
   logic [width-1:0] p_bit;
   logic [width-1:0] carry;
   logic [Pw-1:0]    g_in;
   logic [Pw-1:0]    p_in;
   logic [Pw-1:0]    g_grp;
   logic [Pw-1:0]    p_grp;
   logic [Pw-1:0]    g_nxt;
   logic [Pw-1:0]    p_nxt;

   assign b_eff = b ^ {width{sub}};
   assign p_bit = a ^ b_eff;
   assign g_in  = a[Pw-1:0] & b_eff[Pw-1:0];
   assign p_in  = p_bit[Pw-1:0];

   // g_grp[i]/p_grp[i] end up as generate/propagate of the whole span [0:i].
   always_comb begin : prefix
      g_grp = g_in;
      p_grp = p_in;
      g_nxt = g_in;
      p_nxt = p_in;
      if (speed == 0) begin
         for (int i = 1; i < Pw; i++) begin
            g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i-1]);
            p_grp[i] = p_grp[i] & p_grp[i-1];
         end
      end else if (speed == 1) begin
         for (int l = 0; l < Lv; l++) begin
            g_nxt = g_grp;
            p_nxt = p_grp;
            for (int i = 0; i < Pw; i++) begin
               if (((i + 1) % (2 << l)) == 0) begin
                  g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[i-(1<<l)]);
                  p_nxt[i] = p_grp[i] & p_grp[i-(1<<l)];
               end
            end
            g_grp = g_nxt;
            p_grp = p_nxt;
         end
         // Down-sweep fills the positions the up-sweep tree left partial.
         for (int l = Lv - 2; l >= 0; l--) begin
            g_nxt = g_grp;
            p_nxt = p_grp;
            for (int i = 0; i < Pw; i++) begin
               if ((i >= (2 << l)) && (((i + 1) % (2 << l)) == (1 << l))) begin
                  g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[i-(1<<l)]);
                  p_nxt[i] = p_grp[i] & p_grp[i-(1<<l)];
               end
            end
            g_grp = g_nxt;
            p_grp = p_nxt;
         end
      end else begin
         for (int l = 0; l < Lv; l++) begin
            g_nxt = g_grp;
            p_nxt = p_grp;
            for (int i = 0; i < Pw; i++) begin
               if (((i >> l) & 1) == 1) begin
                  g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[((i >> l) << l) - 1]);
                  p_nxt[i] = p_grp[i] & p_grp[((i >> l) << l) - 1];
               end
            end
            g_grp = g_nxt;
            p_grp = p_nxt;
         end
      end
   end

   assign carry = {g_grp | (p_grp & {Pw{sub}}), sub};
   assign s     = p_bit ^ carry;

endmodule

module addsub_arbiter #(
   parameter  int width  = 8,
   parameter  int speed  = 2,
   parameter  int NumReq = 4,
   localparam int IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NumReq-1:0]       req_valid_i,
   output logic [NumReq-1:0]       req_ready_o,
   input  logic [NumReq*width-1:0] req_a_i,
   input  logic [NumReq*width-1:0] req_b_i,
   input  logic [NumReq-1:0]       req_sub_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [width-1:0]        rsp_s_o,
   output logic [IdW-1:0]          rsp_id_o
);
   // Handshake: a transfer happens on an edge where valid and ready are both 1.
   // req_ready_o never depends on req_valid_i of the same requester except through the
   // grant scan; rsp_valid_o stays high until rsp_ready_i is seen with it.

   logic [IdW-1:0]    ptr;
   logic [IdW-1:0]    ptr_next;
   logic [IdW-1:0]    grant_idx;
   logic [NumReq-1:0] grant;
   logic              any_grant;
   logic              can_accept;
   logic              hs;
   int                scan_idx;
   logic [width-1:0]  op_a;
   logic [width-1:0]  op_b;
   logic              op_sub;
   logic [width-1:0]  sum;

   // First valid requester at or after ptr, wrapping.
   always_comb begin : arbitrate
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      scan_idx  = 0;
      for (int k = 0; k < NumReq; k++) begin
         scan_idx = (int'(ptr) + k) % NumReq;
         if (!any_grant && req_valid_i[scan_idx]) begin
            any_grant        = 1'b1;
            grant[scan_idx]  = 1'b1;
            grant_idx        = IdW'(scan_idx);
         end
      end
   end

   always_comb begin : operand_mux
      op_a   = '0;
      op_b   = '0;
      op_sub = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         if (grant[k]) begin
            op_a   = req_a_i[k*width +: width];
            op_b   = req_b_i[k*width +: width];
            op_sub = req_sub_i[k];
         end
      end
   end

   addsub #(
      .width (width),
      .speed (speed)
   ) u_addsub (
      .a   (op_a),
      .b   (op_b),
      .sub (op_sub),
      .s   (sum)
   );

   assign can_accept  = !rsp_valid_o | rsp_ready_i;
   assign req_ready_o = grant & {NumReq{can_accept & !rst_i}};
   assign hs          = any_grant & can_accept & !rst_i;
   assign ptr_next    = (grant_idx == IdW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_o <= 1'b0;
         rsp_s_o     <= '0;
         rsp_id_o    <= '0;
         ptr         <= '0;
      end else if (hs) begin
         rsp_valid_o <= 1'b1;
         rsp_s_o     <= sum;
         rsp_id_o    <= grant_idx;
         ptr         <= ptr_next;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

   a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));

   a_hold_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
      (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_s_o) && $stable(rsp_id_o)));

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter width, default 8, operand and result word width (>= 2).
REQ-002 SHALL have parameter speed, default 2, prefix performance setting passed unchanged to the shared AddSub instance (0 serial, 1 Brent-Kung, 2 Sklansky).
REQ-003 SHALL have parameter NumReq, default 4, number of requesters (>= 1).
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports named clk_i and rst_i.
REQ-005 SHALL provide port clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL provide port req_valid_i  input  NumReq  per-requester operation valid.
REQ-008 SHALL provide port req_ready_o  output  NumReq  per-requester accept strobe.
REQ-009 SHALL provide port req_a_i  input  NumReq*width  operand A, requester i in bits [i*width +: width].
REQ-010 SHALL provide port req_b_i  input  NumReq*width  operand B, same packing.
REQ-011 SHALL provide port req_sub_i  input  NumReq  1 = A-B, 0 = A+B.
REQ-012 SHALL provide port rsp_valid_o  output  1  result register holds a valid result.
REQ-013 SHALL provide port rsp_ready_i  input  1  downstream consumes result.
REQ-014 SHALL provide port rsp_s_o  output  width  result, modulo 2^width.
REQ-015 SHALL provide port rsp_id_o  output  IdW  index of requester that produced rsp_s_o; IdW = max(1, $clog2(NumReq)).

Function
REQ-016 SHALL instantiate exactly one AddSub (width, speed) datapath, fed by the granted requester's A, B, SUB.
REQ-017 SHALL define can_accept = !rsp_valid_o | rsp_ready_i (combinational).
REQ-018 SHALL grant at most one requester per cycle: the first i with req_valid_i[i]=1 scanning ptr, ptr+1, ..., wrapping mod NumReq.
REQ-019 SHALL drive req_ready_o[i] = grant[i] & can_accept; req_ready_o one-hot or zero.
REQ-020 SHALL treat a handshake on requester i as req_valid_i[i] & req_ready_o[i]; at most one per cycle.
REQ-021 SHALL, on a handshake, load rsp_s_o with AddSub result of that requester's operands, rsp_id_o with i, and set rsp_valid_o=1 on the next edge (latency 1 cycle).
REQ-022 SHALL, on a handshake with requester i, update ptr to (i+1) mod NumReq; ptr otherwise unchanged.
REQ-023 SHALL, when rsp_valid_o & rsp_ready_i and no handshake, clear rsp_valid_o on the next edge.
REQ-024 SHALL, when rsp_valid_o & rsp_ready_i and a handshake occur in the same cycle, replace the result with the new one (rsp_valid_o stays 1): full throughput of one op per cycle.
REQ-025 SHALL hold rsp_s_o, rsp_id_o stable while rsp_valid_o & !rsp_ready_i; no requester accepted.
REQ-026 SHALL not require req_valid_i to be held; a deasserted valid without handshake is simply not granted.
REQ-027 SHALL give ptr-based fairness: a continuously valid requester is granted within NumReq handshakes.
REQ-028 SHALL, for NumReq=1, grant requester 0 whenever valid; ptr constant 0.
REQ-029 SHALL produce no combinational path from rsp_ready_i to rsp_s_o or rsp_id_o.

Reset
REQ-030 SHALL, with rst_i=1 at an edge, set rsp_valid_o=0, rsp_s_o=0, rsp_id_o=0, ptr=0, regardless of concurrent handshakes; req_ready_o=0 while rst_i=1.
REQ-031 SHALL, on reset mid-stream, discard any held result; first request after reset served from ptr=0.

Verification
REQ-032 Reset then req_valid_i=4'b0001, A=0x12, B=0x34, sub=0, rsp_ready_i=1 -> req_ready_o=4'b0001 same cycle; next cycle rsp_valid_o=1, rsp_s_o=0x46, rsp_id_o=0.
REQ-033 Requester 2: A=0x05, B=0x07, sub=1 -> rsp_s_o=0xFE, rsp_id_o=2; A=0xFF, B=0x01, sub=0 -> rsp_s_o=0x00 (wrap).
REQ-034 All four valid continuously, rsp_ready_i=1, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, rsp_id_o sequence 0,1,2,3,0 one cycle later, no idle cycles.
REQ-035 rsp_valid_o=1, rsp_ready_i=0 for 3 cycles with requesters valid -> req_ready_o=0, rsp_s_o/rsp_id_o unchanged; rsp_ready_i=1 -> grant and new result next cycle.
REQ-036 ptr=3, req_valid_i=4'b0110 -> requester 1 granted (wrap), ptr becomes 2; then requester 2 granted.
REQ-037 rst_i=1 in cycle with handshake and rsp_valid_o=1 -> next cycle rsp_valid_o=0, rsp_s_o=0, rsp_id_o=0; all widths checked against behavioural A±B for speed 0,1,2.
